// File: rtl/dec_onehot2bin.sv
// -----------------------------------------------------------------------------
// dec_onehot2bin
//
// Registered one-hot to binary decoder. An accepted N_ONEHOT-bit word is
// turned into the index of its set bit and presented one cycle later on a
// single-entry output register with a valid/ready handshake.
//
//   * exactly one bit i set -> out = i,        out_err = 0
//   * all bits clear        -> out = N_ONEHOT, out_err = 0
//     (the matching encoder drives all zeros for its top code)
//   * two or more bits set  -> out = lowest set bit index, out_err = 1
//
// Every accepted multi-hot word bumps a saturating error counter that can be
// cleared synchronously through err_clr.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   in_valid   in   input word valid
//   in_ready   out  block accepts the word this cycle (combinational)
//   in         in   [N_ONEHOT-1:0] one-hot word
//   out_valid  out  decoded result valid
//   out_ready  in   downstream accepts the result
//   out        out  [BIN_W-1:0] decoded index
//   out_err    out  result came from a multi-hot word
//   err_clr    in   synchronous clear of err_cnt (wins over increment)
//   err_cnt    out  [ERRCNT_W-1:0] saturating count of accepted multi-hot words
// -----------------------------------------------------------------------------
module dec_onehot2bin #(
  parameter int N_ONEHOT = 15,
  parameter int BIN_W    = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_ONEHOT-1:0] in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    out,
  output logic                out_err,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [BIN_W-1:0]    ZERO_CODE = BIN_W'(N_ONEHOT);
  localparam logic [ERRCNT_W-1:0] CNT_MAX   = {ERRCNT_W{1'b1}};
  localparam logic [ERRCNT_W-1:0] CNT_ONE   = {{(ERRCNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_ONEHOT-1:0] WORD_ONE  = {{(N_ONEHOT-1){1'b0}}, 1'b1};

  // Index of the lowest set bit; an all-zero word maps to the top code.
  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, which is exactly the multi-hot resolution rule.
  function automatic logic [BIN_W-1:0] f_lowest_index(input logic [N_ONEHOT-1:0] w);
    logic [BIN_W-1:0] idx;
    idx = ZERO_CODE;
    for (int i = N_ONEHOT - 1; i >= 0; i--) begin
      if (w[i]) begin
        idx = BIN_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // More than one bit set: clearing the lowest set bit (w & (w-1)) leaves
  // something behind only when a second bit was present.
  function automatic logic f_multi_hot(input logic [N_ONEHOT-1:0] w);
    return ((w & (w - WORD_ONE)) != {N_ONEHOT{1'b0}});
  endfunction

  logic                r_out_valid;
  logic [BIN_W-1:0]    r_out;
  logic                r_out_err;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic                w_in_ready;
  logic                w_accept;
  logic [BIN_W-1:0]    w_dec_idx;
  logic                w_dec_err;
  logic                w_cnt_sat;

  // Handshake and decode of the incoming word.
  always_comb begin
    w_in_ready = 1'b0;
    w_accept   = 1'b0;
    w_dec_idx  = ZERO_CODE;
    w_dec_err  = 1'b0;
    w_cnt_sat  = 1'b0;

    // Single output register: it can take a new word when empty or when the
    // current result leaves in the same cycle.
    w_in_ready = !r_out_valid || out_ready;
    w_accept   = in_valid && w_in_ready;
    w_dec_idx  = f_lowest_index(in);
    w_dec_err  = f_multi_hot(in);
    w_cnt_sat  = (r_err_cnt == CNT_MAX);
  end

  // Output occupancy bit: set on accept, cleared on a drain without refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Result register: loads only on accept, so it holds during a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out     <= {BIN_W{1'b0}};
      r_out_err <= 1'b0;
    end else if (w_accept) begin
      r_out     <= w_dec_idx;
      r_out_err <= w_dec_err;
    end else begin
      r_out     <= r_out;
      r_out_err <= r_out_err;
    end
  end

  // Saturating multi-hot counter; clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= {ERRCNT_W{1'b0}};
    end else if (err_clr) begin
      r_err_cnt <= {ERRCNT_W{1'b0}};
    end else if (w_accept && w_dec_err && !w_cnt_sat) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  // Output drive.
  always_comb begin
    in_ready  = w_in_ready;
    out_valid = r_out_valid;
    out       = r_out;
    out_err   = r_out_err;
    err_cnt   = r_err_cnt;
  end

endmodule

// File: tb/tb_dec_onehot2bin.sv
// -----------------------------------------------------------------------------
// Testbench for dec_onehot2bin: directed sequences plus randomized traffic.
// A tracker process models handshake occupancy and the error counter and pushes
// expected results into a queue on every accept; a monitor process pops and
// compares whenever the DUT hands a result downstream.
// -----------------------------------------------------------------------------
module tb_dec_onehot2bin;

  localparam int N = 15;
  localparam int B = 4;
  localparam int C = 8;
  localparam int CNT_MAX = 255;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_word;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] out_idx;
  logic         out_err;
  logic         err_clr;
  logic [C-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int idx;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  bit   model_occ = 1'b0;
  int   model_cnt = 0;

  dec_onehot2bin #(.N_ONEHOT(N), .BIN_W(B), .ERRCNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_idx),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of the set bit, N for an empty word, lowest bit if several.
  function automatic int ref_index(input logic [N-1:0] w);
    if (w == '0) return N;
    for (int i = 0; i < N; i++) begin
      if (w[i]) return i;
    end
    return N;
  endfunction

  function automatic bit ref_err(input logic [N-1:0] w);
    return ($countones(w) > 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] w, input logic v, input logic r, input logic c);
    @(posedge clk);
    #1;
    in_word   = w;
    in_valid  = v;
    out_ready = r;
    err_clr   = c;
  endtask

  // Tracker: checks handshake/counter each cycle and queues expected results.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_occ = 1'b0;
        model_cnt = 0;
        exp_q.delete();
      end else begin
        chk("in_ready", int'(in_ready), int'(!model_occ || out_ready));
        chk("out_valid", int'(out_valid), int'(model_occ));
        chk("err_cnt", int'(err_cnt), model_cnt);
        acc = in_valid && (!model_occ || out_ready);
        if (acc) exp_q.push_back('{idx: ref_index(in_word), err: ref_err(in_word)});
        if (err_clr) model_cnt = 0;
        else if (acc && ref_err(in_word) && model_cnt < CNT_MAX) model_cnt++;
        if (acc) model_occ = 1'b1;
        else if (out_ready) model_occ = 1'b0;
      end
    end
  end

  // Monitor: compares each result as it is handed downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_result: got out=%0d with no pending expectation at %0t", out_idx, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out", int'(out_idx), e.idx);
          chk("out_err", int'(out_err), int'(e.err));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] w;
    int t;
    rst = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out_idx), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Single-hot sweep, zero code, multi-hot.
    for (int i = 0; i < N; i++) drive(N'(1) << i, 1'b1, 1'b1, 1'b0);
    drive(15'h0000, 1'b1, 1'b1, 1'b0);
    drive(15'h0012, 1'b1, 1'b1, 1'b0);
    drive(15'h7FFF, 1'b1, 1'b1, 1'b0);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);
    chk("multi_err_cnt", int'(err_cnt), 2);

    // Backpressure: result 3 held while 1<<7 waits.
    drive(15'h0008, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(15'h0080, 1'b1, 1'b0, 1'b0);
      #3;
      chk("stall_out", int'(out_idx), 3);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    drive(15'h0080, 1'b1, 1'b1, 1'b0);
    #3;
    chk("release_in_ready", int'(in_ready), 1);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);
    #3;
    chk("after_release_out", int'(out_idx), 7);
    chk("after_release_valid", int'(out_valid), 1);

    // Saturation then clear with a simultaneous multi-hot accept.
    for (int k = 0; k < 260; k++) drive(15'h0003, 1'b1, 1'b1, 1'b0);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);
    #3;
    chk("sat_err_cnt", int'(err_cnt), CNT_MAX);
    drive(15'h0005, 1'b1, 1'b1, 1'b1);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);
    #3;
    chk("clr_err_cnt", int'(err_cnt), 0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      t = $urandom_range(0, 3);
      case (t)
        0, 3:    w = N'(1) << $urandom_range(0, N - 1);
        1:       w = '0;
        default: w = N'($urandom);
      endcase
      drive(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 99) == 0));
    end

    // Async reset in the middle of a stall with a multi-hot result pending.
    drive(15'h0006, 1'b1, 1'b1, 1'b0);
    drive(15'h0100, 1'b1, 1'b0, 1'b0);
    #2;
    chk("pre_rst_valid", int'(out_valid), 1);
    chk("pre_rst_err", int'(out_err), 1);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out", int'(out_idx), 0);
    chk("arst_out_err", int'(out_err), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    drive(15'h0400, 1'b1, 1'b1, 1'b0);
    drive(15'h0C00, 1'b1, 1'b1, 1'b0);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) drive(15'h0000, 1'b0, 1'b1, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    drive(15'h0000, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_onehot2bin.md
Name: dec_onehot2bin

Overview:
- Registered one-hot to binary decoder; the receive-side counterpart of the binary to one-hot encoder.
- Takes an N_ONEHOT-bit one-hot word with a valid/ready handshake and returns the index of the set bit as a BIN_W-bit value.
- All-zero input decodes to N_ONEHOT, matching the encoder, which drives all zeros for the top code.
- Flags multi-hot words as errors and keeps a saturating error count for status readout.

Parameters:
- N_ONEHOT, 15: width of the one-hot input; valid codes are 0..N_ONEHOT.
- BIN_W, 4: width of the binary output; must satisfy 2^BIN_W > N_ONEHOT.
- ERRCNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  1  input word is valid.
- in_ready  output  1  block accepts the word this cycle.
- in  input  N_ONEHOT  one-hot word.
- out_valid  output  1  decoded result is valid.
- out_ready  input  1  downstream accepts the result.
- out  output  BIN_W  decoded index.
- out_err  output  1  the result came from a multi-hot word.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  ERRCNT_W  saturating count of accepted multi-hot words.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out=0, out_err=0, err_cnt=0. in_ready is 1 while rst is low. Reset during a pending result drops that result without a handshake.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, combinational ready path).
  - Accept occurs when in_valid && in_ready on a clk edge.
  - Latency: result is visible on out/out_valid the cycle after accept.
  - out and out_err hold stable while out_valid && !out_ready.
  - out_valid clears on (out_valid && out_ready && no new accept).
  - Accept and drain in the same cycle: the register reloads and out_valid stays 1, giving one word per cycle throughput.
- Decode rules for an accepted word w:
  - Exactly one bit i set: out=i, out_err=0.
  - w all zero: out=N_ONEHOT (15 at defaults), out_err=0.
  - Two or more bits set: out = index of the lowest set bit, out_err=1.
- Error counter:
  - err_cnt increments by 1 on each accepted multi-hot word.
  - Saturates at 2^ERRCNT_W-1 with no wrap.
  - err_clr forces 0 on the next edge and takes priority over a simultaneous increment.
  - Counter is unaffected by stalls; only accepted words count.
- in is ignored when in_valid=0; no state changes.
- No internal FSM beyond the out_valid occupancy bit; the block is fully pipelined with one entry.

Test Plan:
- Reset then single-hot sweep: for i=0..14 send in=1<<i with out_ready=1 -> out=i one cycle after accept, out_err=0, err_cnt stays 0.
- Zero code: in=15'h0000, in_valid=1 -> out=15, out_err=0, err_cnt=0.
- Multi-hot: in=15'h0012 -> out=1, out_err=1, err_cnt=1. Then in=15'h7FFF -> out=0, out_err=1, err_cnt=2.
- Backpressure:
  - Send index 3, hold out_ready=0 for 4 cycles while in_valid=1 with in=1<<7 -> in_ready=0, out stays 3 throughout.
  - Raise out_ready -> same cycle in_ready=1; next cycle out=7 with out_valid still 1.
- Saturation and clear:
  - Send 260 multi-hot words -> err_cnt=255.
  - Assert err_clr together with another multi-hot accept -> err_cnt=0.
- Async reset: drop rst mid-stall with out_valid=1 -> out_valid, out, out_err, err_cnt go to 0 immediately without waiting for clk, and in_ready=1.
